// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction-fetch sequencer.
package fetch_pkg;

   localparam int unsigned AW           = 8;
   localparam int unsigned IW           = 16;
   localparam int unsigned QDEPTH_DEF   = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [IW-1:0] data;
   } qentry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, data} words for the decoder.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = QDEPTH_DEF
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     i_push,
   input  qentry_t                  i_entry,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output logic                     o_valid,
   output qentry_t                  o_head,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   qentry_t          r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_pop  = i_pop  & (r_count != '0);
   assign w_push = i_push & (r_count != CW'(DEPTH));

   // Storage, pointers and occupancy; flush empties the queue in one edge.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_entry;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   assign o_valid = (r_count != '0);
   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // The sequencer only requests when there is room, so a full push is a design bug.
   a_no_push_full: assert property (@(posedge CLK) disable iff (!RESET)
      !(i_push && (r_count == CW'(DEPTH))));

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: drives the PC register, issues single-outstanding
// instruction-memory reads and buffers returned words for the decoder.
module fetch_seq
   import fetch_pkg::*;
#(
   parameter int unsigned QDEPTH = QDEPTH_DEF
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic [AW-1:0] pc_cur,
   output logic [AW-1:0] pc_next,
   output logic          pc_load,
   output logic [AW-1:0] pc_target,
   input  logic          br_valid,
   input  logic [AW-1:0] br_target,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_gnt,
   input  logic          imem_rvalid,
   input  logic [IW-1:0] imem_rdata,
   output logic          inst_valid,
   output logic [IW-1:0] inst_data,
   output logic [AW-1:0] inst_pc,
   input  logic          inst_ready
);

   localparam int unsigned CW = $clog2(QDEPTH) + 1;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_req_pc;
   logic [AW-1:0] w_pc_next;
   logic          w_pc_load;
   logic [AW-1:0] w_pc_target;
   logic          w_req;
   logic [AW-1:0] w_addr;
   logic          w_push;
   logic          w_flush;
   logic          w_capture;
   logic          w_space;
   logic          w_outstanding;
   logic [CW-1:0] w_count;
   logic          w_q_valid;
   qentry_t       w_entry;
   qentry_t       w_head;

   assign w_outstanding = (r_state != ST_IDLE);
   assign w_space       = (32'(w_count) + 32'(w_outstanding)) < QDEPTH;

   // State register and address of the request in flight.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state  <= ST_IDLE;
         r_req_pc <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) begin
            r_req_pc <= pc_cur;
         end
      end
   end

   // Next state, PC mux and memory request; a redirect overrides everything.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_next   = pc_cur;
      w_pc_load   = 1'b0;
      w_pc_target = '0;
      w_req       = 1'b0;
      w_addr      = '0;
      w_push      = 1'b0;
      w_flush     = 1'b0;
      w_capture   = 1'b0;
      if (br_valid) begin
         w_pc_load   = 1'b1;
         w_pc_target = br_target;
         w_pc_next   = br_target;
         w_flush     = 1'b1;
         case (r_state)
            ST_IDLE: w_state_nxt = ST_IDLE;
            ST_REQ:  w_state_nxt = imem_rvalid ? ST_IDLE : ST_DROP;
            ST_DROP: w_state_nxt = imem_rvalid ? ST_IDLE : ST_DROP;
            default: w_state_nxt = ST_IDLE;
         endcase
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_space) begin
                  w_req  = 1'b1;
                  w_addr = pc_cur;
                  if (imem_gnt) begin
                     w_pc_next   = pc_cur + AW'(1);
                     w_capture   = 1'b1;
                     w_state_nxt = ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (imem_rvalid) begin
                  w_push      = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_DROP: begin
               if (imem_rvalid) begin
                  w_state_nxt = ST_IDLE;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign w_entry.pc   = r_req_pc;
   assign w_entry.data = imem_rdata;

   fetch_queue #(
      .DEPTH   (QDEPTH)
   ) u_queue (
      .CLK     (CLK),
      .RESET   (RESET),
      .i_push  (w_push),
      .i_entry (w_entry),
      .i_pop   (inst_ready),
      .i_flush (w_flush),
      .o_valid (w_q_valid),
      .o_head  (w_head),
      .o_count (w_count)
   );

   // Control outputs are forced low while reset is held.
   assign pc_next    = RESET ? w_pc_next   : '0;
   assign pc_load    = RESET & w_pc_load;
   assign pc_target  = RESET ? w_pc_target : '0;
   assign imem_req   = RESET & w_req;
   assign imem_addr  = RESET ? w_addr      : '0;
   assign inst_valid = w_q_valid;
   assign inst_data  = w_head.data;
   assign inst_pc    = w_head.pc;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq with a PC-register model and a one-outstanding memory model.
module tb_fetch_seq;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [7:0]  pc_cur;
   logic [7:0]  pc_next;
   logic        pc_load;
   logic [7:0]  pc_target;
   logic        br_valid;
   logic [7:0]  br_target;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        inst_valid;
   logic [15:0] inst_data;
   logic [7:0]  inst_pc;
   logic        inst_ready;

   logic        gnt_en;
   logic        rv_en;
   logic        mem_clr;
   logic        rv_pend = 1'b0;
   logic [7:0]  rv_addr = 8'h00;

   logic [7:0]  grant_log[$];
   logic [7:0]  pop_pc[$];
   logic [15:0] pop_data[$];

   int checks = 0;
   int errors = 0;

   fetch_seq dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .pc_cur      (pc_cur),
      .pc_next     (pc_next),
      .pc_load     (pc_load),
      .pc_target   (pc_target),
      .br_valid    (br_valid),
      .br_target   (br_target),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst_data   (inst_data),
      .inst_pc     (inst_pc),
      .inst_ready  (inst_ready)
   );

   always #5 CLK = ~CLK;

   // PC register: loads every edge, redirect value when pc_load.
   always @(posedge CLK or negedge RESET) begin
      if (!RESET) pc_cur <= 8'h00;
      else        pc_cur <= pc_load ? pc_target : pc_next;
   end

   // Memory: grant gated by gnt_en, data word {B0, addr} returned once rv_en allows.
   assign imem_gnt    = gnt_en & imem_req;
   assign imem_rvalid = rv_en & rv_pend;
   assign imem_rdata  = {8'hB0, rv_addr};

   always @(posedge CLK) begin
      if (mem_clr || imem_rvalid) rv_pend <= 1'b0;
      if (imem_req && imem_gnt) begin
         rv_pend <= 1'b1;
         rv_addr <= imem_addr;
      end
   end

   // Log grants and accepted instructions mid-cycle.
   always @(negedge CLK) begin
      #3;
      if (RESET) begin
         if (imem_req && imem_gnt) grant_log.push_back(imem_addr);
         if (inst_valid && inst_ready) begin
            pop_pc.push_back(inst_pc);
            pop_data.push_back(inst_data);
         end
      end
   end

   task automatic cyc();
      @(negedge CLK);
   endtask

   task automatic do_reset();
      RESET = 1'b0; br_valid = 1'b0; br_target = 8'h00;
      gnt_en = 1'b0; rv_en = 1'b0; inst_ready = 1'b0; mem_clr = 1'b1;
      repeat (2) @(negedge CLK);
      mem_clr = 1'b0;
      RESET = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge CLK);
      RESET = 1'b0; gnt_en = 1'b1; rv_en = 1'b1; inst_ready = 1'b1;
      br_valid = 1'b1; br_target = 8'h5A;
      #1;
      checks++;
      if ({pc_next, pc_load, pc_target, imem_req, imem_addr, inst_valid, inst_data, inst_pc} !== 59'h0) begin
         errors++;
         $display("FAIL reset_outputs: got pc_next=%h pc_load=%b pc_target=%h req=%b addr=%h iv=%b id=%h ipc=%h expected all 0",
                  pc_next, pc_load, pc_target, imem_req, imem_addr, inst_valid, inst_data, inst_pc);
      end
      checks++;
      if (pc_load !== 1'b0) begin errors++; $display("FAIL reset_pc_load: got %b expected 0", pc_load); end
      br_valid = 1'b0;
   endtask

   task automatic test_basic();
      int g0, p0;
      do_reset();
      gnt_en = 1'b1; rv_en = 1'b1; inst_ready = 1'b1;
      g0 = grant_log.size(); p0 = pop_pc.size();
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
         errors++; $display("FAIL basic_first_req: got req=%b addr=%h expected 1/00", imem_req, imem_addr);
      end
      checks++;
      if (pc_next !== 8'h01) begin errors++; $display("FAIL basic_pc_next: got %h expected 01", pc_next); end
      for (int c = 0; c < 6; c++) begin
         cyc(); #1;
         checks++;
         if (pc_load !== 1'b0) begin errors++; $display("FAIL basic_pc_load: got %b expected 0 (cycle %0d)", pc_load, c); end
      end
      checks++;
      if (grant_log.size() - g0 < 3) begin
         errors++; $display("FAIL basic_grant_count: got %0d expected >=3", grant_log.size() - g0);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (grant_log[g0+i] !== 8'(i)) begin
               errors++; $display("FAIL basic_grant_addr: got %h expected %h", grant_log[g0+i], 8'(i));
            end
         end
      end
      checks++;
      if (pop_pc.size() - p0 < 2) begin
         errors++; $display("FAIL basic_pop_count: got %0d expected >=2", pop_pc.size() - p0);
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (pop_pc[p0+i] !== 8'(i) || pop_data[p0+i] !== {8'hB0, 8'(i)}) begin
               errors++; $display("FAIL basic_pop: got pc=%h data=%h expected pc=%h data=%h",
                                  pop_pc[p0+i], pop_data[p0+i], 8'(i), {8'hB0, 8'(i)});
            end
         end
      end
   endtask

   task automatic test_stall();
      int g0, p0, n;
      do_reset();
      gnt_en = 1'b1; rv_en = 1'b1; inst_ready = 1'b0;
      g0 = grant_log.size(); p0 = pop_pc.size();
      repeat (6) cyc();
      #1;
      checks++;
      if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b expected 0", imem_req); end
      checks++;
      if (pc_next !== pc_cur || pc_cur !== 8'h02) begin
         errors++; $display("FAIL stall_pc: got pc_next=%h pc_cur=%h expected both 02", pc_next, pc_cur);
      end
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 8'h00) begin
         errors++; $display("FAIL stall_head: got valid=%b pc=%h expected 1/00", inst_valid, inst_pc);
      end
      inst_ready = 1'b1;
      repeat (12) cyc();
      inst_ready = 1'b0;
      #4;
      n = pop_pc.size() - p0;
      checks++;
      if (n < 5) begin
         errors++; $display("FAIL stall_resume_count: got %0d expected >=5", n);
      end else begin
         for (int i = 0; i < n; i++) begin
            checks++;
            if (pop_pc[p0+i] !== 8'(i) || pop_data[p0+i] !== {8'hB0, 8'(i)}) begin
               errors++; $display("FAIL stall_resume_pop: got pc=%h data=%h expected pc=%h", pop_pc[p0+i], pop_data[p0+i], 8'(i));
            end
         end
      end
      for (int i = 0; i < grant_log.size() - g0; i++) begin
         checks++;
         if (grant_log[g0+i] !== 8'(i)) begin
            errors++; $display("FAIL stall_grant_seq: got %h expected %h", grant_log[g0+i], 8'(i));
         end
      end
   endtask

   task automatic test_redirect_req();
      int p0;
      do_reset();
      gnt_en = 1'b1; rv_en = 1'b0; inst_ready = 1'b1;
      p0 = pop_pc.size();
      cyc();
      br_valid = 1'b1; br_target = 8'h40;
      #1;
      checks++;
      if (pc_load !== 1'b1 || pc_next !== 8'h40 || pc_target !== 8'h40) begin
         errors++; $display("FAIL redir_pulse: got load=%b next=%h target=%h expected 1/40/40", pc_load, pc_next, pc_target);
      end
      cyc();
      br_valid = 1'b0; rv_en = 1'b1;
      #1;
      checks++;
      if (pc_load !== 1'b0 || imem_req !== 1'b0 || pc_cur !== 8'h40) begin
         errors++; $display("FAIL redir_drop: got load=%b req=%b pc_cur=%h expected 0/0/40", pc_load, imem_req, pc_cur);
      end
      cyc(); #1;
      checks++;
      if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_empty: got inst_valid=%b expected 0", inst_valid); end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h40) begin
         errors++; $display("FAIL redir_next_addr: got req=%b addr=%h expected 1/40", imem_req, imem_addr);
      end
      cyc(); cyc(); #1;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 8'h40 || inst_data !== 16'hB040) begin
         errors++; $display("FAIL redir_first_inst: got v=%b pc=%h data=%h expected 1/40/B040", inst_valid, inst_pc, inst_data);
      end
      checks++;
      if (pop_pc.size() != p0) begin errors++; $display("FAIL redir_no_stale: got %0d pops expected 0", pop_pc.size() - p0); end
   endtask

   task automatic test_redirect_pop();
      int p0;
      do_reset();
      gnt_en = 1'b1; rv_en = 1'b1; inst_ready = 1'b0;
      p0 = pop_pc.size();
      cyc(); cyc(); cyc();
      inst_ready = 1'b1; br_valid = 1'b1; br_target = 8'h80;
      #1;
      checks++;
      if (pc_load !== 1'b1 || inst_valid !== 1'b1 || inst_pc !== 8'h00 || imem_rvalid !== 1'b1) begin
         errors++; $display("FAIL brpop_setup: got load=%b v=%b pc=%h rvalid=%b expected 1/1/00/1", pc_load, inst_valid, inst_pc, imem_rvalid);
      end
      cyc();
      br_valid = 1'b0; inst_ready = 1'b0;
      #1;
      checks++;
      if (inst_valid !== 1'b0) begin errors++; $display("FAIL brpop_discard: got inst_valid=%b expected 0", inst_valid); end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h80) begin
         errors++; $display("FAIL brpop_refetch: got req=%b addr=%h expected 1/80", imem_req, imem_addr);
      end
      cyc(); cyc(); #1;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 8'h80 || inst_data !== 16'hB080) begin
         errors++; $display("FAIL brpop_head: got v=%b pc=%h data=%h expected 1/80/B080", inst_valid, inst_pc, inst_data);
      end
      checks++;
      if (pop_pc.size() != p0 + 1) begin
         errors++; $display("FAIL brpop_once: got %0d pops expected 1", pop_pc.size() - p0);
      end else begin
         checks++;
         if (pop_pc[p0] !== 8'h00 || pop_data[p0] !== 16'hB000) begin
            errors++; $display("FAIL brpop_word: got pc=%h data=%h expected 00/B000", pop_pc[p0], pop_data[p0]);
         end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      gnt_en = 1'b0; rv_en = 1'b1; inst_ready = 1'b1;
      br_valid = 1'b1; br_target = 8'hFF;
      cyc();
      br_valid = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'hFF || pc_next !== 8'hFF) begin
         errors++; $display("FAIL wrap_hold: got req=%b addr=%h next=%h expected 1/FF/FF", imem_req, imem_addr, pc_next);
      end
      cyc();
      gnt_en = 1'b1;
      #1;
      checks++;
      if (imem_addr !== 8'hFF || pc_next !== 8'h00) begin
         errors++; $display("FAIL wrap_next: got addr=%h next=%h expected FF/00", imem_addr, pc_next);
      end
      cyc(); #1;
      checks++;
      if (pc_cur !== 8'h00) begin errors++; $display("FAIL wrap_pc_cur: got %h expected 00", pc_cur); end
      cyc(); #1;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 8'hFF || inst_data !== 16'hB0FF || imem_addr !== 8'h00) begin
         errors++; $display("FAIL wrap_inst: got v=%b pc=%h data=%h addr=%h expected 1/FF/B0FF/00", inst_valid, inst_pc, inst_data, imem_addr);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      gnt_en = 1'b0; rv_en = 1'b0; inst_ready = 1'b1;
      br_valid = 1'b1; br_target = 8'h33;
      cyc();
      br_valid = 1'b0; gnt_en = 1'b1;
      cyc();
      gnt_en = 1'b0; RESET = 1'b0;
      #1;
      checks++;
      if ({pc_next, pc_load, pc_target, imem_req, imem_addr, inst_valid, inst_data, inst_pc} !== 59'h0) begin
         errors++; $display("FAIL midrst_outputs: got next=%h load=%b tgt=%h req=%b addr=%h v=%b d=%h pc=%h expected all 0",
                            pc_next, pc_load, pc_target, imem_req, imem_addr, inst_valid, inst_data, inst_pc);
      end
      cyc();
      cyc();
      RESET = 1'b1; rv_en = 1'b1;
      #1;
      checks++;
      if (imem_rvalid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 8'h00) begin
         errors++; $display("FAIL midrst_stray: got rvalid=%b req=%b addr=%h expected 1/1/00", imem_rvalid, imem_req, imem_addr);
      end
      cyc();
      gnt_en = 1'b1;
      #1;
      checks++;
      if (inst_valid !== 1'b0) begin errors++; $display("FAIL midrst_ignored: got inst_valid=%b expected 0", inst_valid); end
      checks++;
      if (imem_addr !== 8'h00 || pc_next !== 8'h01) begin
         errors++; $display("FAIL midrst_first_fetch: got addr=%h next=%h expected 00/01", imem_addr, pc_next);
      end
      cyc(); cyc(); #1;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 8'h00 || inst_data !== 16'hB000) begin
         errors++; $display("FAIL midrst_inst: got v=%b pc=%h data=%h expected 1/00/B000", inst_valid, inst_pc, inst_data);
      end
   endtask

   initial begin
      RESET = 1'b0; br_valid = 1'b0; br_target = 8'h00;
      gnt_en = 1'b0; rv_en = 1'b0; inst_ready = 1'b0; mem_clr = 1'b1;
      test_reset();
      test_basic();
      test_stall();
      test_redirect_req();
      test_redirect_pop();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish before 200000");
      $fatal(1);
   end

endmodule
